// File: rtl/spw_slot_buffer_if.sv
// spw_slot_buffer_if: write/read/status bundle between ingress, arbiter and the slot buffer
interface spw_slot_buffer_if #(
    parameter int PTR_WIDTH  = 3,
    parameter int DATA_WIDTH = 128
);
    localparam int DEPTH = 2 ** PTR_WIDTH;
    logic                  flush_i;
    logic                  wr_valid_i;
    logic                  wr_ready_o;
    logic [DATA_WIDTH-1:0] wr_data_i;
    logic [PTR_WIDTH-1:0]  wr_ptr_o;
    logic                  rd_en_i;
    logic [PTR_WIDTH-1:0]  rd_ptr_i;
    logic                  rd_release_i;
    logic                  rd_valid_o;
    logic [DATA_WIDTH-1:0] rd_data_o;
    logic                  rd_err_o;
    logic [PTR_WIDTH:0]    count_o;
    logic                  full_o;
    logic                  empty_o;
    logic [DEPTH-1:0]      valid_vec_o;

    modport master (
        output flush_i, wr_valid_i, wr_data_i, rd_en_i, rd_ptr_i, rd_release_i,
        input  wr_ready_o, wr_ptr_o, rd_valid_o, rd_data_o, rd_err_o,
               count_o, full_o, empty_o, valid_vec_o
    );
    modport slave (
        input  flush_i, wr_valid_i, wr_data_i, rd_en_i, rd_ptr_i, rd_release_i,
        output wr_ready_o, wr_ptr_o, rd_valid_o, rd_data_o, rd_err_o,
               count_o, full_o, empty_o, valid_vec_o
    );
endinterface

// File: rtl/spw_slot_buffer.sv
// spw_slot_buffer: lowest-free-slot allocating packet-word store with pointer-addressed reads
module spw_slot_buffer #(
    parameter int PTR_WIDTH  = 3,
    parameter int DATA_WIDTH = 128
) (
    input logic clk_i,
    input logic rst_i,
    spw_slot_buffer_if.slave bus
);
    localparam int DEPTH = 2 ** PTR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [PTR_WIDTH:0]    count_q, count_d;
    logic [PTR_WIDTH-1:0]  alloc;
    logic                  rd_valid_q, rd_err_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  full, wr_acc, rel_eff;

    // Downward scan so the lowest free index wins; 0 when nothing is free
    always_comb begin
        alloc = '0;
        for (int i = DEPTH - 1; i >= 0; i--)
            if (!valid_q[i]) alloc = PTR_WIDTH'(i);
    end

    assign full    = count_q == (PTR_WIDTH + 1)'(DEPTH);
    assign wr_acc  = bus.wr_valid_i && !full && !bus.flush_i;
    assign rel_eff = bus.rd_en_i && bus.rd_release_i && valid_q[bus.rd_ptr_i];

    // Released slot is valid and allocated slot is invalid, so the two never collide
    always_comb begin
        valid_d = valid_q;
        if (rel_eff) valid_d[bus.rd_ptr_i] = 1'b0;
        if (wr_acc) valid_d[alloc] = 1'b1;
        valid_d = bus.flush_i ? '0 : valid_d;
        count_d = bus.flush_i ? '0
                : count_q + (PTR_WIDTH + 1)'(wr_acc) - (PTR_WIDTH + 1)'(rel_eff);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q    <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            valid_q    <= valid_d;
            count_q    <= count_d;
            rd_valid_q <= bus.rd_en_i;
            rd_err_q   <= bus.rd_en_i && !valid_q[bus.rd_ptr_i];
            if (bus.rd_en_i) rd_data_q <= mem_q[bus.rd_ptr_i];
        end
    end

    always_ff @(posedge clk_i)
        if (!rst_i && wr_acc) mem_q[alloc] <= bus.wr_data_i;

    assign bus.wr_ready_o  = !full && !bus.flush_i;
    assign bus.wr_ptr_o    = alloc;
    assign bus.rd_valid_o  = rd_valid_q;
    assign bus.rd_data_o   = rd_data_q;
    assign bus.rd_err_o    = rd_err_q;
    assign bus.count_o     = count_q;
    assign bus.full_o      = full;
    assign bus.empty_o     = count_q == '0;
    assign bus.valid_vec_o = valid_q;
endmodule

// File: tb/tb_spw_slot_buffer.sv
// tb_spw_slot_buffer: directed checks of allocation, release, errors, flush and reset
module tb_spw_slot_buffer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    spw_slot_buffer_if #(.PTR_WIDTH(3), .DATA_WIDTH(128)) bus ();
    spw_slot_buffer #(.PTR_WIDTH(3), .DATA_WIDTH(128)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.flush_i = 0; bus.wr_valid_i = 0; bus.rd_en_i = 0; bus.rd_release_i = 0;
    endtask

    always @(negedge clk)
        if (!rst) chk("count_popcount", 128'(bus.count_o), 128'($countones(bus.valid_vec_o)));

    initial begin
        idle();
        bus.wr_data_i = '0;
        bus.rd_ptr_i  = '0;
        tick(); tick();
        rst = 0;
        #1;
        chk("rst_vec", bus.valid_vec_o, 0);
        chk("rst_count", bus.count_o, 0);
        chk("rst_rd_valid", bus.rd_valid_o, 0);
        chk("rst_rd_data", bus.rd_data_o, 0);
        chk("rst_rd_err", bus.rd_err_o, 0);
        chk("rst_empty", bus.empty_o, 1);
        chk("rst_wr_ready", bus.wr_ready_o, 1);

        // fill
        for (int i = 0; i < 8; i++) begin
            bus.wr_valid_i = 1; bus.wr_data_i = 128'(16 + i);
            #1;
            chk("fill_ptr", bus.wr_ptr_o, i);
            chk("fill_ready", bus.wr_ready_o, 1);
            tick();
        end
        bus.wr_data_i = 128'h99;
        #1;
        chk("full_flag", bus.full_o, 1);
        chk("full_count", bus.count_o, 8);
        chk("full_ready", bus.wr_ready_o, 0);
        chk("full_vec", bus.valid_vec_o, 8'hff);
        tick();
        chk("ninth_count", bus.count_o, 8);
        chk("ninth_vec", bus.valid_vec_o, 8'hff);
        idle();

        // out-of-order release
        bus.rd_en_i = 1; bus.rd_release_i = 1; bus.rd_ptr_i = 5;
        tick();
        chk("rel5_valid", bus.rd_valid_o, 1);
        chk("rel5_data", bus.rd_data_o, 128'h15);
        chk("rel5_err", bus.rd_err_o, 0);
        chk("rel5_count", bus.count_o, 7);
        chk("rel5_vec", bus.valid_vec_o, 8'hdf);
        bus.rd_ptr_i = 2;
        tick();
        chk("rel2_data", bus.rd_data_o, 128'h12);
        chk("rel2_count", bus.count_o, 6);
        chk("rel2_vec", bus.valid_vec_o, 8'hdb);
        idle();
        bus.wr_valid_i = 1; bus.wr_data_i = 128'h22;
        #1;
        chk("reuse_ptr2", bus.wr_ptr_o, 2);
        tick();
        chk("idle_rd_valid", bus.rd_valid_o, 0);
        chk("idle_rd_err", bus.rd_err_o, 0);
        chk("hold_rd_data", bus.rd_data_o, 128'h12);
        bus.wr_data_i = 128'h25;
        #1;
        chk("reuse_ptr5", bus.wr_ptr_o, 5);
        tick();
        chk("refill_count", bus.count_o, 8);
        idle();
        bus.rd_en_i = 1; bus.rd_ptr_i = 2;
        tick();
        chk("slot2_data", bus.rd_data_o, 128'h22);
        chk("slot2_count", bus.count_o, 8);

        // release while full plus write: no bypass
        bus.rd_release_i = 1; bus.rd_ptr_i = 3;
        bus.wr_valid_i = 1; bus.wr_data_i = 128'h33;
        #1;
        chk("nobypass_ready", bus.wr_ready_o, 0);
        tick();
        chk("nobypass_count", bus.count_o, 7);
        chk("nobypass_vec", bus.valid_vec_o, 8'hf7);
        chk("nobypass_data", bus.rd_data_o, 128'h13);
        bus.rd_en_i = 0; bus.rd_release_i = 0;
        #1;
        chk("after_ready", bus.wr_ready_o, 1);
        chk("after_ptr", bus.wr_ptr_o, 3);
        tick();
        chk("after_count", bus.count_o, 8);
        idle();

        // error read on empty buffer
        bus.flush_i = 1;
        tick();
        idle();
        chk("flush_empty", bus.empty_o, 1);
        bus.rd_en_i = 1; bus.rd_release_i = 1; bus.rd_ptr_i = 4;
        tick();
        chk("err_valid", bus.rd_valid_o, 1);
        chk("err_flag", bus.rd_err_o, 1);
        chk("err_stale_data", bus.rd_data_o, 128'h14);
        chk("err_count", bus.count_o, 0);
        idle();
        bus.wr_valid_i = 1; bus.wr_data_i = 128'h44;
        tick();
        idle();
        bus.rd_en_i = 1; bus.rd_ptr_i = 0;
        tick();
        chk("ok_err", bus.rd_err_o, 0);
        chk("ok_data", bus.rd_data_o, 128'h44);
        chk("ok_count", bus.count_o, 1);
        idle();

        // flush with concurrent write at count 5
        for (int i = 0; i < 4; i++) begin
            bus.wr_valid_i = 1; bus.wr_data_i = 128'(80 + i);
            tick();
        end
        chk("pre_flush_count", bus.count_o, 5);
        bus.flush_i = 1; bus.wr_data_i = 128'hee;
        #1;
        chk("flush_ready", bus.wr_ready_o, 0);
        tick();
        idle();
        chk("flush_count", bus.count_o, 0);
        chk("flush_empty2", bus.empty_o, 1);
        chk("flush_vec", bus.valid_vec_o, 0);

        // read of the slot being allocated
        bus.wr_valid_i = 1; bus.wr_data_i = 128'h60; bus.rd_en_i = 1; bus.rd_ptr_i = 0;
        tick();
        chk("same_err", bus.rd_err_o, 1);
        chk("same_old_data", bus.rd_data_o, 128'h44);
        chk("same_count", bus.count_o, 1);
        bus.rd_en_i = 0; bus.wr_data_i = 128'h61;
        tick();
        chk("two_vec", bus.valid_vec_o, 8'h03);

        // reset mid-operation
        bus.rd_en_i = 1; bus.rd_ptr_i = 1; bus.wr_data_i = 128'h62;
        rst = 1;
        tick();
        rst = 0;
        idle();
        #1;
        chk("mrst_vec", bus.valid_vec_o, 0);
        chk("mrst_count", bus.count_o, 0);
        chk("mrst_rd_valid", bus.rd_valid_o, 0);
        chk("mrst_rd_data", bus.rd_data_o, 0);
        chk("mrst_rd_err", bus.rd_err_o, 0);
        bus.wr_valid_i = 1; bus.wr_data_i = 128'h70;
        #1;
        chk("mrst_ptr", bus.wr_ptr_o, 0);
        tick();
        idle();
        chk("mrst_count1", bus.count_o, 1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/spw_slot_buffer.md
Name: spw_slot_buffer

Overview:
Slot-addressed packet-word buffer for the cross-bar. It is the next generation of the pointer-addressed slot store.
- Writes are no longer pointer-driven. The block allocates the lowest free slot and returns its pointer to the writer.
- Reads are pointer-addressed with registered data, optional slot release and error flagging.
- Also provides occupancy count, full/empty status and a synchronous flush.
- Sits between the ingress port logic, which writes and records returned pointers, and the cross-bar arbiter, which reads by pointer.

Parameters:
PTR_WIDTH, 3, slot pointer width; DEPTH = 2**PTR_WIDTH slots
DATA_WIDTH, 128, word width in bits

Ports:
clk_i  input  1  clock; all state on rising edge
rst_i  input  1  reset, synchronous, active-high
flush_i  input  1  invalidate all slots
wr_valid_i  input  1  write request
wr_ready_o  output  1  slot available: !full_o && !flush_i
wr_data_i  input  DATA_WIDTH  write data
wr_ptr_o  output  PTR_WIDTH  slot allocated to a write in this cycle; combinational
rd_en_i  input  1  read request
rd_ptr_i  input  PTR_WIDTH  slot to read
rd_release_i  input  1  with rd_en_i: free slot after read
rd_valid_o  output  1  registered: rd_data_o/rd_err_o valid
rd_data_o  output  DATA_WIDTH  registered read data
rd_err_o  output  1  registered: read targeted an invalid slot
count_o  output  PTR_WIDTH+1  number of valid slots
full_o  output  1  count_o == DEPTH
empty_o  output  1  count_o == 0
valid_vec_o  output  DEPTH  per-slot valid bits

Behaviour:
- Reset (sync, rst_i high at posedge):
  - valid_vec_o=0, count_o=0, rd_valid_o=0, rd_data_o=0, rd_err_o=0.
  - Data array is not reset.
  - Reset overrides all other inputs, including flush_i, wr_valid_i and rd_en_i in the same cycle.
- Allocation:
  - wr_ptr_o = lowest index i with valid_vec_o[i]==0, using registered state only.
  - wr_ptr_o = 0 when full; its value is don't-care unless a write is accepted.
- Write:
  - Accepted when wr_valid_i && wr_ready_o.
  - Next cycle: data[wr_ptr_o] = wr_data_i and valid[wr_ptr_o] = 1.
  - wr_valid_i with wr_ready_o low is ignored, with no state change.
- Read:
  - rd_en_i at cycle N gives at N+1: rd_valid_o=1, rd_data_o=data[rd_ptr_i] as of cycle N (pre-write contents), rd_err_o = !valid[rd_ptr_i] as of cycle N.
  - rd_valid_o=0 in cycles after no rd_en_i. rd_data_o holds its last value.
  - rd_err_o=0 whenever rd_valid_o=0.
  - rd_release_i && rd_en_i && slot valid: valid[rd_ptr_i] cleared next cycle.
  - Release of an invalid slot: no effect; rd_err_o still flags.
  - rd_release_i without rd_en_i: ignored.
- Simultaneous events:
  - Write and release in the same cycle: allocation uses pre-cycle valids, so the released slot is not reused that cycle. count_o is net unchanged.
  - Full at cycle start plus release in that cycle: wr_ready_o stays 0 that cycle (no bypass). Ready next cycle.
  - Read of the slot being allocated in the same cycle: rd_err_o=1 (slot was invalid at cycle start); the write completes normally.
- Flush (flush_i=1):
  - wr_ready_o=0.
  - Next cycle: all valids 0, count_o=0.
  - A concurrent read is still serviced against pre-flush state; its release is redundant.
- Count:
  - count_o(next) = count_o + write_accepted - release_effective, with no wrap.
  - The invariant count_o == popcount(valid_vec_o) must always hold; the bench asserts it.
- full_o, empty_o and wr_ready_o are combinational from registered state, plus flush_i for wr_ready_o.
- Slots are reused in lowest-index order, so out-of-order release is fully supported.

Test Plan:
1. Fill (PTR_WIDTH=3): 8 writes, data 0x10..0x17, back-to-back -> wr_ptr_o 0..7, count_o=8, full_o=1, wr_ready_o=0; a 9th wr_valid_i causes no change.
2. Out-of-order release: from full, read+release ptr 5 then ptr 2 -> rd_data_o 0x15 then 0x12 one cycle after each; count_o=6; next write gets ptr 2, the following write gets ptr 5.
3. Simultaneous: full, release ptr 3 with wr_valid_i in the same cycle -> write not accepted, count_o=7; next cycle wr_ready_o=1, wr_ptr_o=3.
4. Error read: empty buffer, rd_en_i with ptr 4 and rd_release_i -> next cycle rd_valid_o=1, rd_err_o=1, count_o stays 0; read of a valid slot without release -> rd_err_o=0, count_o unchanged.
5. Flush: count_o=5, flush_i pulsed with wr_valid_i high -> wr_ready_o=0, next cycle count_o=0, empty_o=1, valid_vec_o=0.
6. Reset mid-operation: rst_i asserted with rd_en_i and wr_valid_i active -> next cycle all outputs at reset values, rd_valid_o=0; first write after reset gets ptr 0.
